// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        XFER   = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

    // Default parameter values
    localparam int GAP_CYCLES_DEF     = 2;
    localparam int TIMEOUT_CYCLES_DEF = 256;

    // Ceiling log2; returns at least 1 so it can size any counter or index
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Client-side and master-side bus of the SPI transaction arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives it.
interface spi_txn_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ack;
    logic                    ack_err;
    logic [DATA_W-1:0]       m_tx_data;
    logic                    m_tx_start;
    logic                    m_done;
    logic                    busy;

    modport slave (
        input  req, req_data, m_done,
        output grant, ack, ack_err, m_tx_data, m_tx_start, busy
    );

    modport master (
        output req, req_data, m_done,
        input  grant, ack, ack_err, m_tx_data, m_tx_start, busy
    );
endinterface

// File: rtl/spi_txn_arbiter_rr_picker.sv
// Combinational round-robin selector: first active request after rr_last_i.
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest hit wins
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_last_i) + k) % N_REQ);
            if (req_i[cand]) idx_o = cand;
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ byte requesters.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    spi_txn_arbiter_if.slave   bus
);
    localparam int IDX_W   = clog2(N_REQ);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    // Abort is taken on the edge where the XFER counter would reach
    // TIMEOUT_CYCLES-1, which puts the abort ack TIMEOUT_CYCLES after LAUNCH.
    localparam logic [CNT_W-1:0] TO_FIRE  = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              ack_err_q, ack_err_d;

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  owner_oh;

    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i     (bus.req),
        .rr_last_i (rr_last_q),
        .valid_o   (pick_vld),
        .idx_o     (pick_idx)
    );

    // State, ownership, latched byte, counter and registered ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_last_q <= IDX_W'(N_REQ - 1);
            data_q    <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Next-state: arbitration in IDLE, timeout/completion in XFER, idle gap in GAP
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        ack_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d   = pick_idx;
                    rr_last_d = pick_idx;
                    data_d    = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = XFER;
            end
            XFER: begin
                // Completion takes priority over a simultaneous timeout
                if (bus.m_done) begin
                    ack_d   = owner_oh;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (cnt_q == TO_FIRE) begin
                    ack_d     = owner_oh;
                    ack_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        bus.grant      = (state_q != IDLE) ? owner_oh : '0;
        bus.m_tx_start = (state_q == LAUNCH);
        bus.busy       = (state_q != IDLE);
        bus.ack        = ack_q;
        bus.ack_err    = ack_err_q;
        bus.m_tx_data  = data_q;
    end
endmodule
